// File: rtl/xalu_pkg.sv
// xalu_pkg -- shared definitions for the extended ALU (HI/LO multiply/divide unit).
// Holds the operation encoding, the FSM state enum and the default latencies
// used as parameter defaults by xalu.
package xalu_pkg;

  // Operation issued from the E stage alongside the start strobe.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MUL   = 3'd6
  } xalu_op_t;

  // Control FSM states: idle, multiply in flight, divide in flight.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } xalu_state_t;

  // Busy cycles for MULT/MULTU/MUL and for DIV/DIVU.
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 34;

endpackage

// File: rtl/xalu_if.sv
// xalu_if -- issue/result bundle between the pipeline and xalu.
// Signals:
//   start, op, src_a, src_b, flush : pipeline -> xalu (issue side)
//   busy, done, hi, lo, mul_result : xalu -> pipeline (status/results)
// Modports: master = pipeline/bench side, slave = xalu side.
interface xalu_if;
  import xalu_pkg::*;

  logic        start;
  xalu_op_t    op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_result;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo, mul_result
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo, mul_result
  );

endinterface

// File: rtl/xalu_div.sv
// xalu_div -- radix-2 restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_start      : load operands and begin 32 iterations
//   i_signed     : treat operands as two's complement (DIV) or unsigned (DIVU)
//   i_a, i_b     : dividend, divisor
//   o_quotient   : quotient, truncated toward zero
//   o_remainder  : remainder, sign follows the dividend
//   o_valid      : high once all 32 iterations have completed
// Divide by zero yields quotient all-ones and remainder equal to the dividend.
module xalu_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_valid
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic [31:0] r_aOrig;
  logic [5:0]  r_cnt;
  logic        r_negQ;
  logic        r_negR;
  logic        r_divZero;
  logic        r_valid;

  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_qBit;
  logic [31:0] w_remNext;

  // Work on magnitudes; the signs are reapplied on the way out.
  assign w_aMag = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_bMag = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;

  // One restoring step: bring the next dividend bit into the partial
  // remainder and subtract the divisor only if it fits.
  assign w_trial   = {r_rem, r_quo[31]};
  assign w_diff    = w_trial - {1'b0, r_divisor};
  assign w_qBit    = (w_trial >= {1'b0, r_divisor});
  assign w_remNext = w_qBit ? w_diff[31:0] : w_trial[31:0];

  // Operand load on start, then 32 shift/subtract iterations. r_quo doubles
  // as the dividend shift register: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_aOrig   <= '0;
      r_cnt     <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_valid   <= 1'b0;
    end else if (i_start) begin
      r_rem     <= '0;
      r_quo     <= w_aMag;
      r_divisor <= w_bMag;
      r_aOrig   <= i_a;
      r_cnt     <= 6'd32;
      r_negQ    <= i_signed & (i_a[31] ^ i_b[31]);
      r_negR    <= i_signed & i_a[31];
      r_divZero <= (i_b == 32'd0);
      r_valid   <= 1'b0;
    end else if (r_cnt != 6'd0) begin
      r_rem <= w_remNext;
      r_quo <= {r_quo[30:0], w_qBit};
      r_cnt <= r_cnt - 6'd1;
      if (r_cnt == 6'd1) begin
        r_valid <= 1'b1;
      end
    end
  end

  // Divide by zero is forced explicitly so that a negative dividend does not
  // get its all-ones quotient negated by the sign fix-up.
  assign o_quotient  = r_divZero ? 32'hFFFF_FFFF : (r_negQ ? (~r_quo + 32'd1) : r_quo);
  assign o_remainder = r_divZero ? r_aOrig       : (r_negR ? (~r_rem + 32'd1) : r_rem);
  assign o_valid     = r_valid;

endmodule

// File: rtl/xalu.sv
// xalu -- multi-cycle HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO and MUL.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : xalu_if.slave (start/op/src_a/src_b/flush in; busy/done/hi/lo/mul_result out)
// Parameters: MULT_LAT (busy cycles for multiplies), DIV_LAT (busy cycles for divides).
// Configuration macro XALU_MUL_EN: when defined, MUL writes the low signed
// product to mul_result; when undefined, MUL is a no-op and mul_result is 0.
module xalu
  import xalu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input logic   clk,
  input logic   reset,
  xalu_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  xalu_state_t r_state;
  xalu_state_t w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;

  logic        w_acceptMul;
  logic        w_acceptDiv;
  logic        w_acceptMtHi;
  logic        w_acceptMtLo;
  logic        w_finish;
  logic        w_opSigned;
  logic [63:0] w_aExt;
  logic [63:0] w_bExt;
  logic        w_isMulOp;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_prod;
  logic        r_done;

  logic [31:0] w_divQuo;
  logic [31:0] w_divRem;
  logic        w_divValid;

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state and accept decode. Acceptance is only possible in IDLE, which
  // also covers the done cycle since the FSM is already back in IDLE then.
  // The counter loads LAT-1 so that busy lasts exactly LAT cycles.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_acceptMul  = 1'b0;
    w_acceptDiv  = 1'b0;
    w_acceptMtHi = 1'b0;
    w_acceptMtLo = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULT, OP_MULTU
`ifdef XALU_MUL_EN
            , OP_MUL
`endif
            : begin
              w_acceptMul = 1'b1;
              w_stateNext = ST_MUL;
              w_cntNext   = CNT_W'(MULT_LAT - 1);
            end
            OP_DIV, OP_DIVU: begin
              w_acceptDiv = 1'b1;
              w_stateNext = ST_DIV;
              w_cntNext   = CNT_W'(DIV_LAT - 1);
            end
            OP_MTHI: w_acceptMtHi = 1'b1;
            OP_MTLO: w_acceptMtLo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Operands are sign- or zero-extended to 64 bits so one multiplier serves
  // MULT, MULTU and MUL; the low 64 bits of the product are exact for both.
  assign w_opSigned = (bus.op != OP_MULTU);
  assign w_aExt     = w_opSigned ? {{32{bus.src_a[31]}}, bus.src_a} : {32'd0, bus.src_a};
  assign w_bExt     = w_opSigned ? {{32{bus.src_b[31]}}, bus.src_b} : {32'd0, bus.src_b};

  xalu_div u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_acceptDiv),
    .i_signed   (bus.op == OP_DIV),
    .i_a        (bus.src_a),
    .i_b        (bus.src_b),
    .o_quotient (w_divQuo),
    .o_remainder(w_divRem),
    .o_valid    (w_divValid)
  );

  // HI/LO datapath. The product is registered at the accept edge from the
  // live operands, so later operand changes cannot affect it; the remaining
  // MULT_LAT cycles give retiming room for the multiplier. Results are only
  // committed on the finishing edge, which reset pre-empts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_prod <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_acceptMtHi) begin
        r_hi <= bus.src_a;
      end
      if (w_acceptMtLo) begin
        r_lo <= bus.src_a;
      end
      if (w_acceptMul) begin
        r_prod <= w_aExt * w_bExt;
      end
      if (w_finish && (r_state == ST_MUL) && !w_isMulOp) begin
        r_hi <= r_prod[63:32];
        r_lo <= r_prod[31:0];
      end
      if (w_finish && (r_state == ST_DIV) && w_divValid) begin
        r_hi <= w_divRem;
        r_lo <= w_divQuo;
      end
    end
  end

`ifdef XALU_MUL_EN
  logic [31:0] r_mulResult;
  logic        r_isMul;

  // MUL shares the multiplier but retires into mul_result, leaving HI/LO alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mulResult <= '0;
      r_isMul     <= 1'b0;
    end else begin
      if (w_acceptMul) begin
        r_isMul <= (bus.op == OP_MUL);
      end
      if (w_finish && (r_state == ST_MUL) && r_isMul) begin
        r_mulResult <= r_prod[31:0];
      end
    end
  end

  assign w_isMulOp      = r_isMul;
  assign bus.mul_result = r_mulResult;
`else
  assign w_isMulOp      = 1'b0;
  assign bus.mul_result = '0;
`endif

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/xalu.md
XALU -- requirements
Module: xalu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  issue strobe from E stage
- op  in  3  xalu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MUL
- src_a  in  32  rs value
- src_b  in  32  rt value
- flush  in  1  exception flush
- busy  out  1  operation in flight; consumed by hazard unit as XALU_Busy
- done  out  1  one-cycle pulse when HI/LO update
- hi  out  32  HI register
- lo  out  32  LO register
- mul_result  out  32  low product of last MUL
REQ-002 Parameters SHALL be:
- MULT_LAT, default 4, busy cycles for MULT/MULTU/MUL
- DIV_LAT, default 34, busy cycles for DIV/DIVU

Function
REQ-003 An op SHALL be accepted on a rising edge where start=1, flush=0 and busy=0; this is cycle 0.
REQ-004 If start=1 and flush=1 in the same cycle, the op SHALL be dropped with no state change.
REQ-005 If start=1 while busy=1, the op SHALL be ignored; the bench flags this as a protocol violation.
REQ-006 MTHI/MTLO SHALL write src_a to hi/lo at the accept edge; busy stays 0; done does not pulse.
REQ-007 The FSM SHALL have states IDLE, MUL, DIV, and a down-counter sized for DIV_LAT.
REQ-008 IDLE->MUL on an accepted MULT/MULTU/MUL; IDLE->DIV on an accepted DIV/DIVU; the counter loads LAT-1.
REQ-009 busy SHALL be 1 in the cycles following acceptance for exactly LAT cycles.
REQ-010 hi, lo and mul_result SHALL update on the edge that ends the last busy cycle, with done=1 for the following single cycle and the FSM returning to IDLE.
REQ-011 A new op SHALL be acceptable in the cycle in which done=1.
REQ-012 MULT SHALL store the signed 64-bit product and MULTU the unsigned product, as {hi,lo}.
REQ-013 MUL SHALL write the low 32 bits of the signed product to mul_result only; hi and lo are unchanged.
REQ-014 DIV/DIVU SHALL use radix-2 restoring iteration, one quotient bit per cycle, producing lo=quotient and hi=remainder.
REQ-015 DIV remainder sign SHALL follow the dividend, with the quotient truncated toward zero.
REQ-016 Divide by zero SHALL give lo=32'hFFFF_FFFF and hi=src_a, with no exception.
REQ-017 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo=32'h8000_0000 and hi=0.
REQ-018 flush while busy SHALL NOT abort the in-flight op, because it was committed at acceptance.
REQ-019 Operands SHALL be captured at the accept edge; later changes on src_a/src_b have no effect.

Reset
REQ-020 reset SHALL force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, mul_result=0 at the next edge.
REQ-021 reset asserted mid-operation SHALL abandon the op with no HI/LO update and no done pulse, and reset has priority over start.

Configuration
REQ-022 With XALU_MUL_EN defined, MUL SHALL behave per REQ-013.
REQ-023 Without XALU_MUL_EN, MUL SHALL be treated as a no-op (no busy, no done), mul_result SHALL be tied to 0, and the MUL datapath is absent.

Structure
REQ-024 The shared package xalu_pkg SHALL hold xalu_op_t, the default MULT_LAT/DIV_LAT constants and the state enum.
REQ-025 The divider iteration SHALL be the sub-module xalu_div (start, signed, a, b -> quotient, remainder, valid), instantiated once.
REQ-026 The multiply SHALL be a registered behavioural product inside xalu, retimed across MULT_LAT.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- MULT a=32'hFFFF_FFFE, b=3 -> busy for 4 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done 1 cycle.
- DIVU a=100, b=7 -> busy for 34 cycles, then lo=14, hi=2.
- DIV a=-7, b=2 -> lo=-3, hi=-1.
- DIV a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5.
- MTLO a=32'h1234 with start=1, flush=1 -> lo unchanged; same op with flush=0 -> lo=32'h1234 next cycle, busy stays 0.
- DIVU started, reset at busy cycle 10 -> busy=0, hi=lo=0 next cycle, no done; a following MULTU 2x3 -> lo=6.
